// File: rtl/peripheral_mult16.sv
// Memory-mapped WIDTHxWIDTH unsigned shift-add multiplier on the femto CPU bus.
// Latency: one cycle for register reads; 16 RUN cycles after the INIT start-write edge.
// Backpressure: none. The CPU is never stalled, and a start write issued during RUN is dropped.
module peripheral_mult16 #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   d_in,
  input  logic               cs,
  input  logic [4:0]         addr,
  input  logic               rd,
  input  logic               wr,
  output logic [2*WIDTH-1:0] d_out
);

  localparam int          CW       = $clog2(WIDTH);
  localparam logic [4:0]  OFF_A    = 5'h04;
  localparam logic [4:0]  OFF_B    = 5'h08;
  localparam logic [4:0]  OFF_INIT = 5'h0C;
  localparam logic [4:0]  OFF_PP   = 5'h10;
  localparam logic [4:0]  OFF_DONE = 5'h14;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   a_w_q, a_w_d;
  logic [WIDTH-1:0]     b_w_q, b_w_d;
  logic [2*WIDTH-1:0]   pp_q, pp_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   d_out_q, d_out_d;

  logic                 wr_en, rd_en, start;
  logic                 last_step;
  logic [2*WIDTH-1:0]   pp_step;
  logic [2*WIDTH-1:0]   pp_view;
  logic                 done_view;

  // Bus decode: a start is honoured only when no multiplication is in flight.
  always_comb begin
    wr_en = cs & wr;
    rd_en = cs & rd;
    start = wr_en && (addr == OFF_INIT) && d_in[0] && (state_q != S_RUN);
  end

  // One shift-add step; the product of two WIDTH-bit values never carries out.
  always_comb begin
    pp_step   = b_w_q[0] ? (pp_q + a_w_q) : pp_q;
    last_step = (state_q == S_RUN) && (count_q == LAST_COUNT);
  end

  // Next-state logic for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_step) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand registers and working datapath. A/B writes during RUN only affect the next start.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    a_w_d   = a_w_q;
    b_w_d   = b_w_q;
    pp_d    = pp_q;
    count_d = count_q;
    done_d  = done_q;

    if (wr_en && (addr == OFF_A)) a_d = d_in;
    if (wr_en && (addr == OFF_B)) b_d = d_in;

    if (start) begin
      a_w_d   = {{WIDTH{1'b0}}, a_q};
      b_w_d   = b_q;
      pp_d    = '0;
      count_d = '0;
      done_d  = 1'b0;
    end else if (state_q == S_RUN) begin
      pp_d    = pp_step;
      a_w_d   = a_w_q << 1;
      b_w_d   = b_w_q >> 1;
      count_d = count_q + 1'b1;
      if (last_step) done_d = 1'b1;
    end
  end

  // Read mux. Reads see the RUN step of the same edge, so a DONE poll on the
  // completing edge already returns 1. A start on that edge is not visible.
  always_comb begin
    pp_view   = (state_q == S_RUN) ? pp_step : pp_q;
    done_view = done_q | last_step;
    d_out_d   = d_out_q;
    if (rd_en) begin
      case (addr)
        OFF_PP:   d_out_d = pp_view;
        OFF_DONE: d_out_d = {{(2*WIDTH-1){1'b0}}, done_view};
        default:  d_out_d = '0;
      endcase
    end
  end

  // State register; reset clears everything, including an in-flight multiplication.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      a_w_q   <= '0;
      b_w_q   <= '0;
      pp_q    <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      d_out_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      a_w_q   <= a_w_d;
      b_w_q   <= b_w_d;
      pp_q    <= pp_d;
      count_q <= count_d;
      done_q  <= done_d;
      d_out_q <= d_out_d;
    end
  end

  assign d_out = d_out_q;

endmodule

// File: tb/tb_peripheral_mult16.sv
// Directed test of the memory-mapped multiplier against a product scoreboard.
// Latency: bus accesses take one clock each, and results are sampled 1ns after the edge.
// Backpressure: none. The bench polls DONE with a bounded loop.
module tb_peripheral_mult16;

  localparam logic [4:0] OFF_A    = 5'h04;
  localparam logic [4:0] OFF_B    = 5'h08;
  localparam logic [4:0] OFF_INIT = 5'h0C;
  localparam logic [4:0] OFF_PP   = 5'h10;
  localparam logic [4:0] OFF_DONE = 5'h14;

  logic        clk;
  logic        reset;
  logic [15:0] d_in;
  logic        cs;
  logic [4:0]  addr;
  logic        rd;
  logic        wr;
  logic [31:0] d_out;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  peripheral_mult16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .d_in  (d_in),
    .cs    (cs),
    .addr  (addr),
    .rd    (rd),
    .wr    (wr),
    .d_out (d_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point; every check goes through here.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One bus cycle: drive on the falling edge, strobe on the rising edge, release 1ns later.
  task automatic bus(input logic [4:0] a, input logic [15:0] dat,
                     input logic c, input logic r, input logic w);
    @(negedge clk);
    addr = a;
    d_in = dat;
    cs   = c;
    rd   = r;
    wr   = w;
    @(posedge clk);
    #1;
    cs = 1'b0;
    rd = 1'b0;
    wr = 1'b0;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [15:0] dat);
    bus(a, dat, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic read_expect(input logic [4:0] a, input logic [31:0] expv, input string tag);
    bus(a, 16'h0, 1'b1, 1'b1, 1'b0);
    chk(tag, d_out, expv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(5'h0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Load operands and start; the model product goes to the scoreboard.
  task automatic start_mult(input logic [15:0] a, input logic [15:0] b);
    write_reg(OFF_A, a);
    write_reg(OFF_B, b);
    exp_q.push_back(32'(a) * 32'(b));
    write_reg(OFF_INIT, 16'h0001);
  endtask

  task automatic poll_done(input string tag);
    logic got;
    int   n;
    got = 1'b0;
    n   = 0;
    while (!got && n < 40) begin
      bus(OFF_DONE, 16'h0, 1'b1, 1'b1, 1'b0);
      got = d_out[0];
      n++;
    end
    chk(tag, {31'b0, got}, 32'd1);
  endtask

  task automatic read_pp(input string tag);
    logic [31:0] expv;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      expv = exp_q.pop_front();
      read_expect(OFF_PP, expv, tag);
    end
  endtask

  initial begin
    reset = 1'b1;
    cs    = 1'b0;
    rd    = 1'b0;
    wr    = 1'b0;
    addr  = 5'h0;
    d_in  = 16'h0;
    #2;
    chk("reset_dout", d_out, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    read_expect(OFF_DONE, 32'h0, "reset_done");
    read_expect(OFF_PP,   32'h0, "reset_pp");

    // Basic product with exact completion timing (start edge T).
    start_mult(16'd3, 16'd5);
    read_expect(OFF_DONE, 32'h0, "basic_done_t1");
    idle(13);
    read_expect(OFF_DONE, 32'h0, "basic_done_t15");
    read_expect(OFF_DONE, 32'h1, "basic_done_t16");
    read_pp("basic_pp");

    // Full-scale and single-bit operands, then a zero operand.
    start_mult(16'hFFFF, 16'hFFFF);
    poll_done("full_done");
    read_pp("full_pp");
    start_mult(16'h8000, 16'd2);
    poll_done("msb_done");
    read_pp("msb_pp");
    start_mult(16'h0000, 16'h1234);
    poll_done("zero_done");
    read_pp("zero_pp");

    // Writes during RUN: a new A and a second start must not disturb 7*9.
    start_mult(16'd7, 16'd9);
    idle(3);
    write_reg(OFF_A, 16'd100);
    write_reg(OFF_INIT, 16'h0001);
    idle(9);
    read_expect(OFF_DONE, 32'h0, "midrun_done_t15");
    read_pp("midrun_pp_t16");
    read_expect(OFF_DONE, 32'h1, "midrun_done_after");
    exp_q.push_back(32'd900);
    write_reg(OFF_INIT, 16'h0001);
    poll_done("restart_done");
    read_pp("restart_pp");

    // Read and write on the same cycle: the unmapped read returns 0 and the start is honoured.
    exp_q.push_back(32'd900);
    bus(OFF_INIT, 16'h0001, 1'b1, 1'b1, 1'b1);
    chk("rdwr_dout", d_out, 32'h0);
    read_expect(OFF_DONE, 32'h0, "rdwr_started");
    poll_done("rdwr_done");
    read_pp("rdwr_pp");

    // Reset in the middle of RUN, after a partial-sum read at T+7.
    start_mult(16'h1234, 16'h5678);
    void'(exp_q.pop_back());
    idle(6);
    exp_q.push_back(32'h1234 * 32'h0078);
    read_pp("partial_pp_t7");
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_dout", d_out, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    read_expect(OFF_DONE, 32'h0, "rst_mid_done");
    read_expect(OFF_PP,   32'h0, "rst_mid_pp");
    start_mult(16'h1234, 16'h5678);
    poll_done("post_rst_done");
    read_pp("post_rst_pp");

    // Decode: a read with cs low, an unmapped offset, and an INIT write with bit 0 clear.
    bus(OFF_DONE, 16'h0, 1'b0, 1'b1, 1'b0);
    chk("cs_low_hold", d_out, 32'h0626_0060);
    read_expect(5'h18, 32'h0, "unmapped_read");
    write_reg(OFF_INIT, 16'h0000);
    read_expect(OFF_DONE, 32'h1, "init0_done_kept");
    read_expect(OFF_PP, 32'h0626_0060, "init0_pp_kept");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
